// File: rtl/fetch_unit.sv
// fetch_unit: decoupled instruction fetch with an in-order tag queue, an instruction FIFO and
// redirect discard. Optional perf counters are enabled by defining FETCH_PERF_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h1c000000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic        fs_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  input  logic        id_allowin
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] ZERO      = CW'(1'b0);
  localparam logic [CW-1:0] ONE       = CW'(1'b1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TAG_LAST  = TW'(MAX_OUTSTANDING - 1);

  logic [31:0]   pc;
  logic [CW-1:0] outstanding, outstanding_next;
  logic [CW-1:0] discard, discard_next;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_sum;
  logic [31:0]   tag_q [MAX_OUTSTANDING];
  logic [TW-1:0] tag_wr, tag_rd;
  logic [31:0]   fifo_pc_mem   [FIFO_DEPTH];
  logic [31:0]   fifo_inst_mem [FIFO_DEPTH];
  logic [AW-1:0] fifo_wr, fifo_rd;
  logic          accept, resp, push, pop;

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    if (p == TAG_LAST) return TW'(1'b0);
    else return p + TW'(1'b1);
  endfunction

  assign inst_addr  = pc;
  assign credit_sum = {1'b0, outstanding} + {1'b0, fifo_count};
  assign fs_pc      = fs_valid ? fifo_pc_mem[fifo_rd] : 32'h0;
  assign fs_inst    = fs_valid ? fifo_inst_mem[fifo_rd] : 32'h0;

  // Request credit reserves a FIFO slot for every in-flight fetch, so responses never overflow.
  always_comb begin
    inst_req = 1'b0;
    if (!reset && (outstanding < MAX_OUT_C) && (credit_sum < {1'b0, DEPTH_C}))
      inst_req = 1'b1;
    else
      inst_req = 1'b0;
    accept   = inst_req & inst_addr_ok;
    resp     = inst_data_ok & (outstanding != ZERO);
    fs_valid = ~reset & (fifo_count != ZERO);
    push     = resp & (discard == ZERO) & ~br_valid;
    pop      = fs_valid & id_allowin & ~br_valid;
    if (accept && !resp)
      outstanding_next = outstanding + ONE;
    else if (resp && !accept)
      outstanding_next = outstanding - ONE;
    else
      outstanding_next = outstanding;
    // A redirect drops everything still unanswered after this cycle, including a same-cycle accept.
    if (br_valid)
      discard_next = outstanding_next;
    else if (resp && (discard != ZERO))
      discard_next = discard - ONE;
    else
      discard_next = discard;
  end

  // Control state: PC, credit counters and queue pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      outstanding <= ZERO;
      discard     <= ZERO;
      tag_wr      <= TW'(1'b0);
      tag_rd      <= TW'(1'b0);
      fifo_wr     <= AW'(1'b0);
      fifo_rd     <= AW'(1'b0);
      fifo_count  <= ZERO;
    end else begin
      if (br_valid)
        pc <= br_target;
      else if (accept)
        pc <= pc + 32'd4;
      outstanding <= outstanding_next;
      discard     <= discard_next;
      if (accept) tag_wr <= tag_inc(tag_wr);
      if (resp)   tag_rd <= tag_inc(tag_rd);
      if (br_valid) begin
        fifo_wr    <= AW'(1'b0);
        fifo_rd    <= AW'(1'b0);
        fifo_count <= ZERO;
      end else begin
        if (push) fifo_wr <= fifo_wr + AW'(1'b1);
        if (pop)  fifo_rd <= fifo_rd + AW'(1'b1);
        if (push && !pop)
          fifo_count <= fifo_count + ONE;
        else if (pop && !push)
          fifo_count <= fifo_count - ONE;
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (accept) tag_q[tag_wr] <= pc;
    if (push) begin
      fifo_pc_mem[fifo_wr]   <= tag_q[tag_rd];
      fifo_inst_mem[fifo_wr] <= inst_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  // Decode-side throughput and bubble counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt <= 32'h0;
      perf_stall_cnt <= 32'h0;
    end else begin
      if (pop)       perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (!fs_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

  a_no_stray_resp: assert property (@(posedge clk) disable iff (reset)
    inst_data_ok |-> (outstanding != ZERO));
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    push |-> ((fifo_count != DEPTH_C) || pop));

endmodule
